// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the ALU command sequencer slice:
//               ALU opcodes, load-button bit positions and the sequencer
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Opcode encoding understood by the ALU top-level
  localparam int unsigned     OP_W   = 6;
  localparam logic [OP_W-1:0] OP_ADD = 6'd32;
  localparam logic [OP_W-1:0] OP_SUB = 6'd34;
  localparam logic [OP_W-1:0] OP_AND = 6'd36;
  localparam logic [OP_W-1:0] OP_OR  = 6'd37;
  localparam logic [OP_W-1:0] OP_XOR = 6'd38;
  localparam logic [OP_W-1:0] OP_NOR = 6'd39;
  localparam logic [OP_W-1:0] OP_SRL = 6'd2;
  localparam logic [OP_W-1:0] OP_SRA = 6'd3;

  // Bit positions on the button bus
  localparam int unsigned BTN_LOAD_A  = 0;
  localparam int unsigned BTN_LOAD_B  = 1;
  localparam int unsigned BTN_LOAD_OP = 2;

  // Sequencer FSM states
  localparam int unsigned     ST_W       = 3;
  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD_A  = 3'd1;
  localparam logic [ST_W-1:0] ST_GAP_A   = 3'd2;
  localparam logic [ST_W-1:0] ST_LOAD_B  = 3'd3;
  localparam logic [ST_W-1:0] ST_GAP_B   = 3'd4;
  localparam logic [ST_W-1:0] ST_LOAD_OP = 3'd5;
  localparam logic [ST_W-1:0] ST_SETTLE  = 3'd6;
  localparam logic [ST_W-1:0] ST_RESPOND = 3'd7;

endpackage
`default_nettype wire

// File: rtl/alu_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : alu_ref_model
// Description : Combinational golden model of the ALU. Produces the result
//               expected for operands A/B and an opcode, truncated to
//               NB_DATA. Shifts use the full unsigned B as the amount.
// Ports       : i_data_a  - operand A
//               i_data_b  - operand B (also the shift amount)
//               i_op      - opcode
//               o_result  - expected result
//               o_known   - 1 when i_op is a modelled opcode
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic [NB_OP-1:0]   i_op,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_known
);

  always_comb begin
    o_result = '0;
    o_known  = 1'b1;
    case (i_op)
      NB_OP'(OP_ADD): o_result = i_data_a + i_data_b;
      NB_OP'(OP_SUB): o_result = i_data_a - i_data_b;
      NB_OP'(OP_AND): o_result = i_data_a & i_data_b;
      NB_OP'(OP_OR):  o_result = i_data_a | i_data_b;
      NB_OP'(OP_XOR): o_result = i_data_a ^ i_data_b;
      NB_OP'(OP_NOR): o_result = ~(i_data_a | i_data_b);
      // Native shifts already saturate for amounts >= NB_DATA
      NB_OP'(OP_SRL): o_result = i_data_a >> i_data_b;
      NB_OP'(OP_SRA): o_result = NB_DATA'($signed(i_data_a) >>> i_data_b);
      default:        o_known  = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Takes one {A, B, op} command over valid/ready, replays it on
//               the button/switch bus as load A, load B, load op, waits a
//               settle interval, captures i_leds and returns it over a
//               valid/ready response channel.
// Ports       : i_clock, i_reset (async, active-low)
//               i_cmd_valid/o_cmd_ready, i_data_a, i_data_b, i_op : command
//               o_buttons, o_switches, i_leds                    : ALU side
//               o_rsp_valid/i_rsp_ready, o_rsp_data              : response
//               o_mismatch                                       : self-check
// Options     : define ALU_SEQ_SELFCHECK_EN to compare the captured result
//               against alu_ref_model; otherwise o_mismatch is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int NB_DATA       = 8,
  parameter int NB_OP         = 6,
  parameter int NB_BUTTONS    = 3,
  parameter int HOLD_CYCLES   = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [NB_DATA-1:0]    i_data_a,
  input  logic [NB_DATA-1:0]    i_data_b,
  input  logic [NB_OP-1:0]      i_op,
  output logic [NB_BUTTONS-1:0] o_buttons,
  output logic [NB_DATA-1:0]    o_switches,
  input  logic [NB_DATA-1:0]    i_leds,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [NB_DATA-1:0]    o_rsp_data,
  output logic                  o_mismatch
);

  localparam int c_CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_RELOAD   = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_SETTLE_RELOAD = c_CNT_W'(SETTLE_CYCLES - 1);

  logic [ST_W-1:0]       r_state;
  logic [ST_W-1:0]       w_state_nxt;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_CNT_W-1:0]    w_cnt_reload;
  logic                  w_cnt_zero;

  logic [NB_DATA-1:0]    r_data_a;
  logic [NB_DATA-1:0]    r_data_b;
  logic [NB_OP-1:0]      r_op;

  logic                  r_cmd_ready;
  logic [NB_BUTTONS-1:0] r_buttons;
  logic [NB_DATA-1:0]    r_switches;
  logic                  r_rsp_valid;
  logic [NB_DATA-1:0]    r_rsp_data;

  logic                  w_cmd_ready_nxt;
  logic [NB_BUTTONS-1:0] w_buttons_nxt;
  logic [NB_DATA-1:0]    w_switches_nxt;
  logic                  w_rsp_valid_nxt;
  logic [NB_DATA-1:0]    w_rsp_data_nxt;

  logic                  w_accept;
  logic                  w_capture;
  logic                  w_rsp_done;

  assign w_cnt_zero = (r_cnt == '0);
  // r_cmd_ready is only ever high in IDLE, so it doubles as the accept gate
  assign w_accept   = (r_state == ST_IDLE) && r_cmd_ready && i_cmd_valid;
  assign w_capture  = (r_state == ST_SETTLE) && (w_state_nxt == ST_RESPOND);
  assign w_rsp_done = (r_state == ST_RESPOND) && i_rsp_ready;

  // -------- FSM: state register --------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------- FSM: next state and counter reload --------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept)   w_state_nxt = ST_LOAD_A;
      ST_LOAD_A:  if (w_cnt_zero) w_state_nxt = ST_GAP_A;
      ST_GAP_A:                   w_state_nxt = ST_LOAD_B;
      ST_LOAD_B:  if (w_cnt_zero) w_state_nxt = ST_GAP_B;
      ST_GAP_B:                   w_state_nxt = ST_LOAD_OP;
      ST_LOAD_OP: if (w_cnt_zero) w_state_nxt = ST_SETTLE;
      ST_SETTLE:  if (w_cnt_zero) w_state_nxt = ST_RESPOND;
      ST_RESPOND: if (i_rsp_ready) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase

    w_cnt_reload = '0;
    case (w_state_nxt)
      ST_LOAD_A, ST_LOAD_B, ST_LOAD_OP: w_cnt_reload = c_HOLD_RELOAD;
      ST_SETTLE:                        w_cnt_reload = c_SETTLE_RELOAD;
      default:                          w_cnt_reload = '0;
    endcase
  end

  // -------- FSM: registered output values, decoded from the next state --------
  always_comb begin
    w_buttons_nxt   = '0;
    w_switches_nxt  = r_switches;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_valid_nxt = (w_state_nxt == ST_RESPOND);
    w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
    case (w_state_nxt)
      ST_LOAD_A: begin
        w_buttons_nxt[BTN_LOAD_A] = 1'b1;
        // On the accept edge the latch is not yet loaded, so take the port
        w_switches_nxt = (r_state == ST_IDLE) ? i_data_a : r_data_a;
      end
      ST_LOAD_B: begin
        w_buttons_nxt[BTN_LOAD_B] = 1'b1;
        w_switches_nxt = r_data_b;
      end
      ST_LOAD_OP: begin
        w_buttons_nxt[BTN_LOAD_OP] = 1'b1;
        w_switches_nxt = NB_DATA'(r_op);
      end
      default: ;
    endcase
    if (w_capture) begin
      w_rsp_data_nxt = i_leds;
    end
  end

  // Dwell counter: reloaded on every state change, counts down to zero
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= w_cnt_reload;
    end else if (!w_cnt_zero) begin
      r_cnt <= r_cnt - c_CNT_W'(1);
    end
  end

  // Command latch
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_data_a <= '0;
      r_data_b <= '0;
      r_op     <= '0;
    end else if (w_accept) begin
      r_data_a <= i_data_a;
      r_data_b <= i_data_b;
      r_op     <= i_op;
    end
  end

  // Output registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cmd_ready <= 1'b0;
      r_buttons   <= '0;
      r_switches  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_cmd_ready <= w_cmd_ready_nxt;
      r_buttons   <= w_buttons_nxt;
      r_switches  <= w_switches_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_buttons   = r_buttons;
  assign o_switches  = r_switches;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;

`ifdef ALU_SEQ_SELFCHECK_EN
  logic [NB_DATA-1:0] w_expected;
  logic               w_known;
  logic               r_mismatch;

  alu_ref_model #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP)
  ) u_ref_model (
    .i_data_a (r_data_a),
    .i_data_b (r_data_b),
    .i_op     (r_op),
    .o_result (w_expected),
    .o_known  (w_known)
  );

  // Evaluated alongside the result capture so it is valid with o_rsp_valid
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_mismatch <= 1'b0;
    end else if (w_capture) begin
      r_mismatch <= w_known && (w_expected != i_leds);
    end else if (w_rsp_done) begin
      r_mismatch <= 1'b0;
    end
  end

  assign o_mismatch = r_mismatch;
`else
  assign o_mismatch = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer. A small ALU-top
//               model sits on the button/switch/LED bus; a table of
//               commands with hand-computed results is replayed, plus
//               sequences for backpressure, busy, mid-sequence reset and
//               self-check behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  localparam int NB_DATA       = 8;
  localparam int NB_OP         = 6;
  localparam int NB_BUTTONS    = 3;
  localparam int HOLD_CYCLES   = 1;
  localparam int SETTLE_CYCLES = 2;
  localparam int LAT           = 3 * (HOLD_CYCLES + 1) + SETTLE_CYCLES;
  localparam int BUDGET        = 40;
`ifdef ALU_SEQ_SELFCHECK_EN
  localparam logic SELFCHECK = 1'b1;
`else
  localparam logic SELFCHECK = 1'b0;
`endif

  logic                  clk;
  logic                  i_reset;
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic [NB_DATA-1:0]    i_data_a;
  logic [NB_DATA-1:0]    i_data_b;
  logic [NB_OP-1:0]      i_op;
  logic [NB_BUTTONS-1:0] o_buttons;
  logic [NB_DATA-1:0]    o_switches;
  logic [NB_DATA-1:0]    i_leds;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [NB_DATA-1:0]    o_rsp_data;
  logic                  o_mismatch;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .NB_DATA       (NB_DATA),
    .NB_OP         (NB_OP),
    .NB_BUTTONS    (NB_BUTTONS),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_data_a    (i_data_a),
    .i_data_b    (i_data_b),
    .i_op        (i_op),
    .o_buttons   (o_buttons),
    .o_switches  (o_switches),
    .i_leds      (i_leds),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_mismatch  (o_mismatch)
  );

  // ---------------- ALU top model ----------------
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      6'd32:   return a + b;
      6'd34:   return a - b;
      6'd36:   return a & b;
      6'd37:   return a | b;
      6'd38:   return a ^ b;
      6'd39:   return ~(a | b);
      6'd2:    return (b >= 8'd8) ? 8'h00 : (a >> b[2:0]);
      6'd3:    return (b >= 8'd8) ? {8{a[7]}} : 8'($signed(a) >>> b[2:0]);
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] alu_a  = '0;
  logic [7:0] alu_b  = '0;
  logic [5:0] alu_op = '0;
  logic       leds_force  = 1'b0;
  logic [7:0] leds_forced = '0;

  always @(posedge clk) begin
    if (o_buttons[0]) alu_a  <= o_switches;
    if (o_buttons[1]) alu_b  <= o_switches;
    if (o_buttons[2]) alu_op <= o_switches[5:0];
  end

  always_comb i_leds = leds_force ? leds_forced : alu_f(alu_a, alu_b, alu_op);

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0] data;
    logic       mis;
  } exp_t;
  exp_t sb_q[$];

  logic [2:0] seq_btn [1:7];
  logic [7:0] seq_sw  [1:7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                           input logic [7:0] exp_d, input logic exp_m);
    int n;
    n = 0;
    while (!o_cmd_ready && n < BUDGET) begin
      tick();
      n++;
    end
    if (!o_cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_ready_timeout: got 0 required 1");
    end
    i_cmd_valid = 1'b1;
    i_data_a    = a;
    i_data_b    = b;
    i_op        = op;
    tick();
    i_cmd_valid = 1'b0;
    sb_q.push_back('{data: exp_d, mis: exp_m});
  endtask

  // k0 is the cycle index after the accept edge the caller is currently in
  task automatic wait_rsp(input int k0, output int lat);
    int k;
    k   = k0;
    lat = -1;
    while (k <= BUDGET) begin
      if (k >= 1 && k <= 7) begin
        seq_btn[k] = o_buttons;
        seq_sw[k]  = o_switches;
      end
      if (o_rsp_valid) begin
        lat = k;
        break;
      end
      tick();
      k++;
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no o_rsp_valid required one within %0d cycles", BUDGET);
    end
  endtask

  task automatic check_rsp(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: got empty queue required an entry", name);
      return;
    end
    e = sb_q.pop_front();
    chk({name, "_data"}, 64'(o_rsp_data), 64'(e.data));
    chk({name, "_mismatch"}, 64'(o_mismatch), 64'(e.mis));
  endtask

  task automatic handshake();
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    chk("hs_valid_low", 64'(o_rsp_valid), 64'd0);
    chk("hs_cmd_ready", 64'(o_cmd_ready), 64'd1);
    chk("hs_mismatch_clr", 64'(o_mismatch), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int         lat;
    int         seen;
    logic [20:0] act_btn;
    logic [55:0] act_sw;
    logic [55:0] exp_sw;
    logic [7:0]  op8;

    vecs[0]  = '{8'h0F, 8'h01, 6'd32, 8'h10};  // ADD
    vecs[1]  = '{8'h80, 8'h03, 6'd3,  8'hF0};  // SRA negative
    vecs[2]  = '{8'h80, 8'h03, 6'd2,  8'h10};  // SRL
    vecs[3]  = '{8'h10, 8'h20, 6'd34, 8'hF0};  // SUB borrow
    vecs[4]  = '{8'hF0, 8'h3C, 6'd36, 8'h30};  // AND
    vecs[5]  = '{8'hF0, 8'h0F, 6'd37, 8'hFF};  // OR
    vecs[6]  = '{8'hAA, 8'hFF, 6'd38, 8'h55};  // XOR
    vecs[7]  = '{8'hA0, 8'h05, 6'd39, 8'h5A};  // NOR
    vecs[8]  = '{8'h80, 8'h09, 6'd3,  8'hFF};  // SRA amount >= width
    vecs[9]  = '{8'hFF, 8'h08, 6'd2,  8'h00};  // SRL amount >= width
    vecs[10] = '{8'hFF, 8'h01, 6'd32, 8'h00};  // ADD wrap
    vecs[11] = '{8'h12, 8'h34, 6'd1,  8'h00};  // unknown op
    vecs[12] = '{8'h70, 8'h02, 6'd3,  8'h1C};  // SRA positive

    i_reset     = 1'b0;
    i_cmd_valid = 1'b0;
    i_data_a    = '0;
    i_data_b    = '0;
    i_op        = '0;
    i_rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_buttons", 64'(o_buttons), 64'd0);
    chk("rst_switches", 64'(o_switches), 64'd0);
    chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(o_rsp_data), 64'd0);
    chk("rst_mismatch", 64'(o_mismatch), 64'd0);
    i_reset = 1'b1;
    tick();
    chk("rst_release_cmd_ready", 64'(o_cmd_ready), 64'd1);

    // Table-driven commands
    for (int i = 0; i < NV; i++) begin
      issue_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, 1'b0);
      wait_rsp(1, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(LAT));
      act_btn = '0;
      act_sw  = '0;
      for (int k = 1; k <= 7; k++) begin
        act_btn = {act_btn[17:0], seq_btn[k]};
        act_sw  = {act_sw[47:0], seq_sw[k]};
      end
      op8    = {2'b00, vecs[i].op};
      exp_sw = {vecs[i].a, vecs[i].a, vecs[i].b, vecs[i].b, op8, op8, op8};
      chk($sformatf("v%0d_button_seq", i), 64'(act_btn), 64'(21'b001_000_010_000_100_000_000));
      chk($sformatf("v%0d_switch_seq", i), 64'(act_sw), 64'(exp_sw));
      check_rsp($sformatf("v%0d", i));
      handshake();
    end

    // Backpressure: response held while i_leds toggles
    issue_cmd(8'h0F, 8'h01, 6'd32, 8'h10, 1'b0);
    wait_rsp(1, lat);
    leds_force = 1'b1;
    for (int c = 0; c < 5; c++) begin
      leds_forced = (c % 2 == 0) ? 8'h5A : 8'hA5;
      tick();
      chk("bp_data", 64'(o_rsp_data), 64'h10);
      chk("bp_valid", 64'(o_rsp_valid), 64'd1);
      chk("bp_cmd_ready", 64'(o_cmd_ready), 64'd0);
    end
    check_rsp("bp");
    handshake();
    leds_force = 1'b0;

    // Busy: a second command during LOAD_B is ignored
    issue_cmd(8'h0F, 8'h01, 6'd32, 8'h10, 1'b0);
    tick();
    tick();
    chk("busy_in_load_b", 64'(o_buttons), 64'b010);
    i_cmd_valid = 1'b1;
    i_data_a    = 8'h55;
    i_data_b    = 8'h55;
    i_op        = 6'd38;
    tick();
    i_cmd_valid = 1'b0;
    wait_rsp(4, lat);
    chk("busy_latency", 64'(lat), 64'(LAT));
    check_rsp("busy");
    handshake();
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (o_rsp_valid) seen++;
    end
    chk("busy_no_second_rsp", 64'(seen), 64'd0);

    // Reset asserted in GAP_B
    issue_cmd(8'h0F, 8'h01, 6'd32, 8'h10, 1'b0);
    tick();
    tick();
    tick();
    chk("gapb_switches_hold_b", 64'(o_switches), 64'h01);
    i_reset = 1'b0;
    #1;
    chk("midrst_buttons", 64'(o_buttons), 64'd0);
    chk("midrst_switches", 64'(o_switches), 64'd0);
    chk("midrst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("midrst_rsp_data", 64'(o_rsp_data), 64'd0);
    chk("midrst_mismatch", 64'(o_mismatch), 64'd0);
    chk("midrst_cmd_ready", 64'(o_cmd_ready), 64'd0);
    void'(sb_q.pop_back());
    tick();
    tick();
    i_reset = 1'b1;
    tick();
    chk("midrst_release_cmd_ready", 64'(o_cmd_ready), 64'd1);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (o_rsp_valid) seen++;
    end
    chk("midrst_no_rsp", 64'(seen), 64'd0);

    // Self-check: wrong LED value for ADD 3+4
    leds_force  = 1'b1;
    leds_forced = 8'h00;
    issue_cmd(8'h03, 8'h04, 6'd32, 8'h00, SELFCHECK);
    wait_rsp(1, lat);
    chk("selfchk_latency", 64'(lat), 64'(LAT));
    check_rsp("selfchk");
    handshake();
    leds_force = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the button/switch/LED operand-load protocol used by the ALU top-level.
- Accepts one command (operand A, operand B, opcode) over a valid/ready handshake.
- Replays it onto o_buttons/o_switches as the load sequence A, then B, then op.
- Waits a settle interval, captures i_leds and returns the result over a valid/ready response channel.
- Sits between a host (UART front-end or bench) and the existing ALU top.

Parameters:
- NB_DATA, 8, operand/switch/LED width.
- NB_OP, 6, opcode width; zero-extended onto switches.
- NB_BUTTONS, 3, button bus width; bit0 = load A, bit1 = load B, bit2 = load op.
- HOLD_CYCLES, 1, cycles each button is held high (≥1).
- SETTLE_CYCLES, 2, cycles after op-button release before i_leds is sampled (≥1).

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command ready; high only in IDLE.
- i_data_a  in  NB_DATA  operand A.
- i_data_b  in  NB_DATA  operand B.
- i_op  in  NB_OP  opcode.
- o_buttons  out  NB_BUTTONS  one-hot load strobes to the ALU top.
- o_switches  out  NB_DATA  data to the ALU top.
- i_leds  in  NB_DATA  result from the ALU top.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response ready.
- o_rsp_data  out  NB_DATA  captured result.
- o_mismatch  out  1  self-check flag; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset values: o_buttons=0, o_switches=0, o_rsp_valid=0, o_rsp_data=0, o_mismatch=0, state=IDLE (o_cmd_ready=1 once reset deasserts). All outputs are registered.
- States: IDLE → LOAD_A → GAP_A → LOAD_B → GAP_B → LOAD_OP → SETTLE → RESPOND → IDLE.
- IDLE: on i_cmd_valid & o_cmd_ready, latch A, B and op; go to LOAD_A.
- LOAD_x: o_buttons = one-hot for x, o_switches = value; lasts HOLD_CYCLES.
- GAP_x: 1 cycle; o_buttons=0, o_switches unchanged, so the switch value is stable around the falling edge of the strobe.
- LOAD_OP → SETTLE: o_switches = {zero-pad, op}, o_buttons=0, for SETTLE_CYCLES.
- SETTLE: on its last cycle, i_leds is registered into o_rsp_data; o_rsp_valid rises the following cycle (RESPOND).
- Latency: o_rsp_valid is first high 3*(HOLD_CYCLES+1)+SETTLE_CYCLES cycles after the accept edge (8 with defaults).
- RESPOND: o_rsp_valid and o_rsp_data are held stable until i_rsp_ready. i_leds changes are ignored. On handshake, go to IDLE; o_cmd_ready rises the next cycle (no same-cycle bypass).
- i_cmd_valid while not IDLE: ignored, no queuing.
- Reset asserted mid-sequence: immediate return to reset values; in-flight command dropped; no response generated.
- Counters: single down-counter sized $clog2(max(HOLD_CYCLES,SETTLE_CYCLES)+1), reloaded on each state entry.

Optional Feature:
- Macro: ALU_SEQ_SELFCHECK_EN.
- With the macro: a golden model computes the expected result from latched A, B and op. o_mismatch (registered, valid with o_rsp_valid, cleared on handshake) = expected ≠ captured.
- Golden ops: 32 ADD, 34 SUB, 36 AND, 37 OR, 38 XOR, 39 NOR, 2 SRL, 3 SRA.
- Golden width rules: results truncated to NB_DATA; SRA treats A as signed; shift amount is the full unsigned B (≥NB_DATA gives all zeros or all sign bits).
- Unknown op: o_mismatch=0.
- Without the macro: o_mismatch is constant 0 and no model logic is synthesized.

Decomposition:
- Shared package alu_pkg: opcode localparams (OP_ADD=32, OP_SUB=34, OP_AND=36, OP_OR=37, OP_XOR=38, OP_NOR=39, OP_SRL=2, OP_SRA=3), button bit indices, FSM state encoding.
- Sub-module alu_ref_model: combinational golden model, instantiated only under ALU_SEQ_SELFCHECK_EN.

Test Plan:
- Add: A=0x0F, B=0x01, op=32, ALU top attached → o_buttons sequence 001,000,010,000,100,000,000; o_switches 0x0F, 0x0F, 0x01, 0x01, 0x20…; o_rsp_valid at cycle 8; o_rsp_data=0x10.
- SRA: A=0x80, B=0x03, op=3 → o_rsp_data=0xF0, o_mismatch=0. Then SRL, same operands → 0x10.
- Backpressure: hold i_rsp_ready=0 for 5 cycles while i_leds toggles → o_rsp_data constant, o_cmd_ready=0; release → IDLE, o_cmd_ready=1 one cycle later.
- Busy: pulse i_cmd_valid with A=0x55 during LOAD_B → ignored; the response reflects only the first command.
- Reset at GAP_B → all outputs 0 immediately; after release o_cmd_ready=1 and no o_rsp_valid appears.
- Self-check: with the macro defined, bench forces i_leds=0x00 for A=0x03, B=0x04, op=32 → o_mismatch=1 with o_rsp_valid; without the macro, o_mismatch stays 0.
